// File: rtl/control_unit.sv
// Multicycle Moore control unit for the cpu datapath.
// Sequences fetch, decode and per-instruction execute/writeback states and
// decodes every datapath control signal from the current state.
// Optional feature: define CTRL_EXCEPTION_EN to enable overflow and
// unknown-instruction exceptions (EPC save, vector read, PC load).
module control_unit #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned STATE_W  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Overflow,
  input  logic       Zero,
  output logic       PC_write,
  output logic [1:0] IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       A_write,
  output logic       B_write,
  output logic       ALUOut_write,
  output logic       EPC_write,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       seletor_ulaA,
  output logic [1:0] seletor_ulaB,
  output logic [2:0] Seletor,
  output logic [1:0] PCSource,
  output logic [2:0] ShiftOP,
  output logic       SrInputSrc,
  output logic [1:0] SrNSrc
);

  localparam int unsigned CntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_WAIT);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;

  typedef enum logic [STATE_W-1:0] {
    StReset, StFetch, StDecode, StREx, StRWb, StShLd, StShOp, StShWb, StJr,
    StIEx, StIWb, StAddr, StMemRd, StLwWb, StMemWr, StBr, StJmp,
    StExcEpc, StExcRd, StExcPc
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;   // cycle counter for memory-wait states
  logic            last_cyc;

`ifdef CTRL_EXCEPTION_EN
  logic cause_q, cause_d;          // 1: overflow, 0: unknown instruction
`else
  logic unused_ovf;
  assign unused_ovf = Overflow;
`endif

  assign last_cyc = (cnt_q == CntLast);

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
`ifdef CTRL_EXCEPTION_EN
    cause_d = cause_q;
`endif
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        if (last_cyc) state_d = StDecode;
        else          cnt_d   = cnt_q + 1'b1;
      end
      StDecode: begin
`ifdef CTRL_EXCEPTION_EN
        state_d = StExcEpc;
        cause_d = 1'b0;
`else
        state_d = StFetch;
`endif
        case (opcode)
          OpR: begin
            case (funct)
              FnAdd, FnSub, FnAnd: state_d = StREx;
              FnSll, FnSrl:        state_d = StShLd;
              FnJr:                state_d = StJr;
              default: ;
            endcase
          end
          OpAddi:     state_d = StIEx;
          OpLw, OpSw: state_d = StAddr;
          OpBeq, OpBne: state_d = StBr;
          OpJ:        state_d = StJmp;
          default: ;
        endcase
      end
      StREx: begin
        state_d = StRWb;
`ifdef CTRL_EXCEPTION_EN
        // and cannot overflow; only add/sub trap
        if (Overflow && (funct != FnAnd)) begin
          state_d = StExcEpc;
          cause_d = 1'b1;
        end
`endif
      end
      StShLd: state_d = StShOp;
      StShOp: state_d = StShWb;
      StIEx: begin
        state_d = StIWb;
`ifdef CTRL_EXCEPTION_EN
        if (Overflow) begin
          state_d = StExcEpc;
          cause_d = 1'b1;
        end
`endif
      end
      StAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (last_cyc) state_d = StLwWb;
        else          cnt_d   = cnt_q + 1'b1;
      end
`ifdef CTRL_EXCEPTION_EN
      StExcEpc: state_d = StExcRd;
      StExcRd: begin
        if (last_cyc) state_d = StExcPc;
        else          cnt_d   = cnt_q + 1'b1;
      end
      StExcPc: state_d = StFetch;
`endif
      StRWb, StShWb, StJr, StIWb, StLwWb, StMemWr, StBr, StJmp: state_d = StFetch;
      default: state_d = StReset;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReset;
      cnt_q   <= '0;
`ifdef CTRL_EXCEPTION_EN
      cause_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CTRL_EXCEPTION_EN
      cause_q <= cause_d;
`endif
    end
  end

  // Moore output decode; only the branch enable looks at Zero directly
  always_comb begin
    PC_write     = 1'b0;
    IorD         = 2'b00;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    A_write      = 1'b0;
    B_write      = 1'b0;
    ALUOut_write = 1'b0;
    EPC_write    = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 2'b00;
    MemToReg     = 2'b00;
    seletor_ulaA = 1'b0;
    seletor_ulaB = 2'b00;
    Seletor      = 3'b000;
    PCSource     = 2'b00;
    ShiftOP      = 3'b000;
    SrInputSrc   = 1'b0;
    SrNSrc       = 2'b00;
    case (state_q)
      StFetch: begin
        seletor_ulaB = 2'b01;
        Seletor      = 3'b001;
        IRWrite      = last_cyc;
        PC_write     = last_cyc;
      end
      StDecode: begin
        A_write      = 1'b1;
        B_write      = 1'b1;
        ALUOut_write = 1'b1;
        seletor_ulaB = 2'b11;
        Seletor      = 3'b001;
      end
      StREx: begin
        seletor_ulaA = 1'b1;
        ALUOut_write = 1'b1;
        case (funct)
          FnAdd:   Seletor = 3'b001;
          FnSub:   Seletor = 3'b010;
          FnAnd:   Seletor = 3'b011;
          default: Seletor = 3'b000;
        endcase
      end
      StRWb, StShWb: begin
        RegDst   = 2'b01;
        MemToReg = (state_q == StShWb) ? 2'b10 : 2'b00;
        RegWrite = 1'b1;
      end
      StShLd: ShiftOP = 3'b001;
      StShOp: ShiftOP = (funct == FnSrl) ? 3'b011 : 3'b010;
      StJr: begin
        seletor_ulaA = 1'b1;
        PC_write     = 1'b1;
      end
      StIEx, StAddr: begin
        seletor_ulaA = 1'b1;
        seletor_ulaB = 2'b10;
        Seletor      = 3'b001;
        ALUOut_write = 1'b1;
      end
      StIWb: RegWrite = 1'b1;
      StMemRd: IorD = 2'b01;
      StLwWb: begin
        MemToReg = 2'b01;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 2'b01;
        MemWrite = 1'b1;
      end
      StBr: begin
        seletor_ulaA = 1'b1;
        Seletor      = 3'b010;
        PCSource     = 2'b01;
        PC_write     = (opcode == OpBne) ? ~Zero : Zero;
      end
      StJmp: begin
        PC_write = 1'b1;
        PCSource = 2'b10;
      end
`ifdef CTRL_EXCEPTION_EN
      StExcEpc: begin
        EPC_write    = 1'b1;
        seletor_ulaB = 2'b01;
        Seletor      = 3'b010;
      end
      StExcRd: IorD = cause_q ? 2'b11 : 2'b10;
      StExcPc: begin
        PC_write = 1'b1;
        PCSource = 2'b11;
      end
`endif
      default: ;
    endcase
  end

endmodule
